imem_dmem_responder: RTL and testbench



---
 rtl/imem_dmem_responder.sv | 169 ++++++++++++++++
 tb/tb_imem_dmem_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_dmem_responder.sv
// Memory-side responder for the CPU fetch/store port: sweeps, host-loads, then serves the CPU.
// Optional stored even parity per word is enabled with `define IMEM_DMEM_PARITY_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_CLEAR | zero-fill sweep, one word per cycle, CPU held in reset
// ST_LOAD  | host streams program words from ptr 0, CPU held in reset
// ST_RUN   | CPU released; registered reads, write-first on address match
module imem_dmem_responder #(
   parameter int ADDR_W         = 11,
   parameter int DATA_W         = 32,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              read_mem,
   input  logic              write_mem,
   input  logic [ADDR_W-1:0] mem_radrs,
   input  logic [ADDR_W-1:0] mem_wadrs,
   input  logic [DATA_W-1:0] result,
   output logic [DATA_W-1:0] instruction_fetch,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              cpu_resetn,
   output logic              parity_err
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_LOAD  = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   localparam state_t ST_INIT = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_LOAD;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_next;
   logic              ptr_at_end;
   logic              accept;
   logic              ready_next;
   logic              run_next;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic              bypass;
   logic [DATA_W-1:0] rd_word;

   assign ptr_at_end = (ptr == ADDR_W'(DEPTH - 1));
   // load_ready is a flop, so a beat is taken only when the host saw ready high
   assign accept     = load_valid & load_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_INIT;
         ptr        <= '0;
         load_ready <= 1'b0;
         cpu_resetn <= 1'b0;
      end else begin
         state      <= state_next;
         ptr        <= ptr_next;
         load_ready <= ready_next;
         cpu_resetn <= run_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      case (state)
         ST_CLEAR: begin
            ptr_next = ptr + 1'b1;
            if (ptr_at_end) begin
               ptr_next   = '0;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (accept) begin
               ptr_next = ptr + 1'b1;
               if (load_last || ptr_at_end) begin
                  ptr_next   = '0;
                  state_next = ST_RUN;
               end
            end
         end
         ST_RUN:  state_next = ST_RUN;
         default: begin
            state_next = ST_INIT;
            ptr_next   = '0;
         end
      endcase
   end

   always_comb begin
      ready_next = (state_next == ST_LOAD);
      run_next   = (state_next == ST_RUN);
   end

   // Single write port shared by sweep, loader and CPU; the state picks the owner.
   always_comb begin
      mem_we = 1'b0;
      mem_wa = ptr;
      mem_wd = '0;
      case (state)
         ST_CLEAR: mem_we = 1'b1;
         ST_LOAD: begin
            mem_we = accept;
            mem_wd = load_data;
         end
         ST_RUN: begin
            mem_we = write_mem;
            mem_wa = mem_wadrs;
            mem_wd = result;
         end
         default: mem_we = 1'b0;
      endcase
      if (reset) mem_we = 1'b0;
   end

   assign bypass  = write_mem && (mem_wadrs == mem_radrs);
   assign rd_word = bypass ? result : mem[mem_radrs];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instruction_fetch <= '0;
      end else if (state != ST_RUN) begin
         instruction_fetch <= '0;
      end else if (read_mem) begin
         instruction_fetch <= rd_word;
      end
   end

`ifdef IMEM_DMEM_PARITY_EN
   logic mem_par [DEPTH];
   logic rd_par;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_wa]     <= mem_wd;
         mem_par[mem_wa] <= ^mem_wd;
      end
   end

   assign rd_par = bypass ? ^result : mem_par[mem_radrs];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_err <= 1'b0;
      end else if ((state == ST_RUN) && read_mem && ((^rd_word) != rd_par)) begin
         parity_err <= 1'b1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_dmem_responder.sv
// Self-checking bench for imem_dmem_responder: clear sweep, host load, CPU traffic vs a word-array model.
module tb_imem_dmem_responder;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2048;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              read_mem = 1'b0;
   logic              write_mem = 1'b0;
   logic [ADDR_W-1:0] mem_radrs = '0;
   logic [ADDR_W-1:0] mem_wadrs = '0;
   logic [DATA_W-1:0] result = '0;
   logic [DATA_W-1:0] instruction_fetch;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_last = 1'b0;
   logic              load_ready;
   logic              cpu_resetn;
   logic              parity_err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_W-1:0] model [DEPTH];
   logic [DATA_W-1:0] words [DEPTH];

   imem_dmem_responder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLEAR_ON_RESET(1)) dut (
      .clk(clk), .reset(reset), .read_mem(read_mem), .write_mem(write_mem),
      .mem_radrs(mem_radrs), .mem_wadrs(mem_wadrs), .result(result),
      .instruction_fetch(instruction_fetch), .load_valid(load_valid),
      .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
      .cpu_resetn(cpu_resetn), .parity_err(parity_err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // Returns the number of edges until load_ready rises, -1 on timeout.
   task automatic wait_clear(output int cyc);
      cyc = -1;
      for (int k = 1; k <= 2200; k++) begin
         tick();
         if (load_ready === 1'b1) begin
            cyc = k;
            break;
         end
      end
   endtask

   task automatic beat(input logic [DATA_W-1:0] w, input logic last);
      load_valid = 1'b1;
      load_data  = w;
      load_last  = last;
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic test_reset();
      int  rise;
      logic bad;
      repeat (3) tick();
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL rst_load_ready: got %b want 0", load_ready); end
      n_checks++; if (cpu_resetn !== 1'b0) begin n_fail++; $display("FAIL rst_cpu_resetn: got %b want 0", cpu_resetn); end
      n_checks++; if (instruction_fetch !== 32'h0) begin n_fail++; $display("FAIL rst_fetch: got %h want 0", instruction_fetch); end
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rst_parity: got %b want 0", parity_err); end
      reset = 1'b0;
      // stray CPU enables during the sweep must be ignored
      read_mem = 1'b1; mem_radrs = 11'd8;
      write_mem = 1'b1; mem_wadrs = 11'd8; result = 32'hA5A5_5A5A;
      rise = -1;
      bad  = 1'b0;
      for (int k = 1; k <= 2200; k++) begin
         tick();
         if (load_ready === 1'b1) begin
            rise = k;
            break;
         end
         if (cpu_resetn !== 1'b0 || instruction_fetch !== 32'h0) bad = 1'b1;
      end
      read_mem = 1'b0; write_mem = 1'b0;
      n_checks++; if (rise != DEPTH) begin n_fail++; $display("FAIL clear_duration: got %0d cycles want %0d", rise, DEPTH); end
      n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL clear_outputs: cpu_resetn/fetch moved during sweep, got %b want 0", bad); end
      model_clear();
   endtask

   task automatic test_load3();
      read_mem = 1'b1; mem_radrs = 11'd9;
      write_mem = 1'b1; mem_wadrs = 11'd9; result = 32'h1234_5678;
      beat(32'h8000_0001, 1'b0);
      n_checks++; if (cpu_resetn !== 1'b0) begin n_fail++; $display("FAIL load_cpu_held: got %b want 0", cpu_resetn); end
      n_checks++; if (instruction_fetch !== 32'h0) begin n_fail++; $display("FAIL load_fetch_zero: got %h want 0", instruction_fetch); end
      beat(32'h8000_0002, 1'b0);
      load_last = 1'b1;
      repeat (2) tick();
      load_last = 1'b0;
      n_checks++; if (cpu_resetn !== 1'b0) begin n_fail++; $display("FAIL last_wo_valid: cpu_resetn got %b want 0", cpu_resetn); end
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL gap_ready: got %b want 1", load_ready); end
      beat(32'hE000_0005, 1'b1);
      read_mem = 1'b0; write_mem = 1'b0;
      n_checks++; if (cpu_resetn !== 1'b1) begin n_fail++; $display("FAIL run_entry: cpu_resetn got %b want 1", cpu_resetn); end
      n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL run_ready: got %b want 0", load_ready); end
      model[0] = 32'h8000_0001;
      model[1] = 32'h8000_0002;
      model[2] = 32'hE000_0005;
   endtask

   task automatic test_read_hold();
      read_mem = 1'b1; mem_radrs = 11'd1;
      tick();
      n_checks++; if (instruction_fetch !== model[1]) begin n_fail++; $display("FAIL read1: got %h want %h", instruction_fetch, model[1]); end
      read_mem = 1'b0; mem_radrs = 11'd2;
      tick();
      n_checks++; if (instruction_fetch !== model[1]) begin n_fail++; $display("FAIL hold: got %h want %h", instruction_fetch, model[1]); end
      read_mem = 1'b1; mem_radrs = 11'd9;
      tick();
      n_checks++; if (instruction_fetch !== model[9]) begin n_fail++; $display("FAIL stray_write: got %h want %h", instruction_fetch, model[9]); end
      read_mem = 1'b0;
   endtask

   task automatic test_write_first();
      write_mem = 1'b1; mem_wadrs = 11'd7; result = 32'hDEAD_BEEF;
      read_mem  = 1'b1; mem_radrs = 11'd7;
      tick();
      model[7] = 32'hDEAD_BEEF;
      n_checks++; if (instruction_fetch !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL write_first: got %h want deadbeef", instruction_fetch); end
      write_mem = 1'b0; mem_radrs = 11'd8;
      tick();
      n_checks++; if (instruction_fetch !== model[8]) begin n_fail++; $display("FAIL neighbour8: got %h want %h", instruction_fetch, model[8]); end
      mem_radrs = 11'd7;
      tick();
      n_checks++; if (instruction_fetch !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL readback7: got %h want deadbeef", instruction_fetch); end
      read_mem = 1'b0;
   endtask

   task automatic test_random_traffic();
      logic [DATA_W-1:0] expv;
      logic              rd, wr;
      logic [ADDR_W-1:0] ra, wa;
      logic [DATA_W-1:0] d;
      expv = model[7];
      for (int i = 0; i < 300; i++) begin
         rd = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         ra = ADDR_W'($urandom_range(0, 15));
         wa = ($urandom_range(0, 3) == 0) ? ra : ADDR_W'($urandom_range(0, 15));
         d  = $urandom;
         read_mem = rd; mem_radrs = ra;
         write_mem = wr; mem_wadrs = wa; result = d;
         if (rd) expv = (wr && wa == ra) ? d : model[ra];
         if (wr) model[wa] = d;
         tick();
         n_checks++; if (instruction_fetch !== expv) begin n_fail++; $display("FAIL rand_fetch[%0d]: got %h want %h", i, instruction_fetch, expv); end
      end
      read_mem = 1'b0; write_mem = 1'b0;
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL rand_parity: got %b want 0", parity_err); end
   endtask

   task automatic test_full_load();
      int cyc, accepted, budget;
      logic v;
      #2 reset = 1'b1;
      #1;
      n_checks++; if (cpu_resetn !== 1'b0 || load_ready !== 1'b0 || instruction_fetch !== 32'h0) begin
         n_fail++; $display("FAIL run_reset_async: got cpu_resetn=%b ready=%b fetch=%h want 0/0/0", cpu_resetn, load_ready, instruction_fetch); end
      tick();
      reset = 1'b0;
      wait_clear(cyc);
      n_checks++; if (cyc != DEPTH) begin n_fail++; $display("FAIL full_clear: got %0d cycles want %0d", cyc, DEPTH); end
      model_clear();
      for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
      accepted = 0;
      budget   = 0;
      while (accepted < DEPTH && budget < 6000) begin
         v = ($urandom_range(0, 3) != 0);
         load_valid = v; load_data = words[accepted]; load_last = 1'b0;
         tick();
         budget++;
         if (v) begin
            accepted++;
            if (accepted == DEPTH - 1) begin
               n_checks++; if (cpu_resetn !== 1'b0) begin n_fail++; $display("FAIL full_early_run: got %b want 0", cpu_resetn); end
            end
         end
      end
      n_checks++; if (accepted != DEPTH) begin n_fail++; $display("FAIL full_budget: accepted %0d want %0d", accepted, DEPTH); end
      n_checks++; if (cpu_resetn !== 1'b1 || load_ready !== 1'b0) begin
         n_fail++; $display("FAIL full_forced_run: got cpu_resetn=%b ready=%b want 1/0", cpu_resetn, load_ready); end
      load_valid = 1'b1; load_data = 32'hBAD0_BAD0;
      tick();
      load_valid = 1'b0;
      for (int i = 0; i < DEPTH; i++) model[i] = words[i];
      for (int j = 0; j < 6; j++) begin
         logic [ADDR_W-1:0] a;
         a = (j == 0) ? 11'd0 : (j == 1) ? 11'd2047 : ADDR_W'($urandom_range(0, DEPTH - 1));
         read_mem = 1'b1; mem_radrs = a;
         tick();
         n_checks++; if (instruction_fetch !== model[a]) begin n_fail++; $display("FAIL full_read[%0d]: got %h want %h", a, instruction_fetch, model[a]); end
      end
      read_mem = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      int cyc;
      logic [DATA_W-1:0] w [3];
      #2 reset = 1'b1;
      #1;
      tick();
      reset = 1'b0;
      wait_clear(cyc);
      n_checks++; if (cyc != DEPTH) begin n_fail++; $display("FAIL mid_clear1: got %0d cycles want %0d", cyc, DEPTH); end
      for (int i = 0; i < 5; i++) beat($urandom | 32'h1, 1'b0);
      n_checks++; if (load_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", load_ready); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (load_ready !== 1'b0 || cpu_resetn !== 1'b0 || instruction_fetch !== 32'h0 || parity_err !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_vals: got ready=%b cpu=%b fetch=%h par=%b want 0/0/0/0", load_ready, cpu_resetn, instruction_fetch, parity_err); end
      tick();
      reset = 1'b0;
      wait_clear(cyc);
      n_checks++; if (cyc != DEPTH) begin n_fail++; $display("FAIL mid_clear2: got %0d cycles want %0d", cyc, DEPTH); end
      model_clear();
      for (int i = 0; i < 3; i++) begin
         w[i] = $urandom;
         model[i] = w[i];
         beat(w[i], (i == 2));
      end
      n_checks++; if (cpu_resetn !== 1'b1) begin n_fail++; $display("FAIL mid_reload_run: got %b want 1", cpu_resetn); end
      for (int a = 0; a < 5; a++) begin
         read_mem = 1'b1; mem_radrs = ADDR_W'(a);
         tick();
         n_checks++; if (instruction_fetch !== model[a]) begin n_fail++; $display("FAIL mid_read[%0d]: got %h want %h", a, instruction_fetch, model[a]); end
      end
      read_mem = 1'b0;
   endtask

   task automatic test_parity();
`ifdef IMEM_DMEM_PARITY_EN
      dut.mem[3] = dut.mem[3] ^ 32'h0000_0001;
      read_mem = 1'b1; mem_radrs = 11'd3;
      tick();
      read_mem = 1'b0;
      n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_set: got %b want 1", parity_err); end
      repeat (3) tick();
      n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_sticky: got %b want 1", parity_err); end
      #2 reset = 1'b1;
      #1;
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_reset: got %b want 0", parity_err); end
      tick();
      reset = 1'b0;
`else
      read_mem = 1'b1; mem_radrs = 11'd3;
      tick();
      read_mem = 1'b0;
      n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_tied: got %b want 0", parity_err); end
      n_checks++; if (instruction_fetch !== model[3]) begin n_fail++; $display("FAIL read3: got %h want %h", instruction_fetch, model[3]); end
`endif
   endtask

   initial begin
      test_reset();
      test_load3();
      test_read_hold();
      test_write_first();
      test_random_traffic();
      test_full_load();
      test_reset_mid_load();
      test_parity();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
